// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with ALU flags.
// Stage 1 registers operands and per-nibble propagate/generate terms;
// stage 2 resolves nibble carries through group lookahead, forms the sum
// and flags, and registers everything on the output side.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_valid / o_ready       operand handshake (upstream)
//   i_op_a, i_op_b, i_sub   operands; i_sub=1 selects A - B
//   o_valid / i_ready       result handshake (downstream)
//   o_result                sum or difference (modulo 2^WIDTH)
//   o_carry                 carry-out of MSB (subtract: 1 = no borrow)
//   o_overflow              signed overflow
//   o_zero, o_negative      result == 0, result MSB
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned GRP = NIB / 4;

  // Block {P, G} of one 4-bit slice; G is the carry-out with carry-in 0.
  function automatic logic [1:0] nib_pg(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    p = a | b;
    g = a & b;
    return {&p, g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [NIB-1:0]   s1_p;
  logic [NIB-1:0]   s1_g;

  logic             s2_adv;
  logic [WIDTH-1:0] b_eff_c;
  logic [NIB-1:0]   p_c;
  logic [NIB-1:0]   g_c;
  logic [NIB-1:0]   nib_cin_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Ready propagates back through the two stages; no skid buffer.
  assign s2_adv  = !o_valid | i_ready;
  assign o_ready = !s1_valid | s2_adv;

  // Operand conditioning for subtract: B is inverted, carry-in supplied by i_sub.
  assign b_eff_c = i_op_b ^ {WIDTH{i_sub}};

  // Per-nibble propagate/generate from the incoming operands.
  always_comb begin
    p_c = '0;
    g_c = '0;
    for (int k = 0; k < int'(NIB); k++) begin
      {p_c[k], g_c[k]} = nib_pg(i_op_a[4*k +: 4], b_eff_c[4*k +: 4]);
    end
  end

  // Carry resolution: group P*/G* across groups of 4 nibbles, with the
  // nibble carries inside a group derived from the group's carry-in.
  always_comb begin : resolve
    logic       gc;
    logic       nc;
    logic       gp;
    logic       gg;
    logic [3:0] pn;
    logic [3:0] gn;
    nib_cin_c = '0;
    gc        = s1_cin;
    nc        = 1'b0;
    gp        = 1'b0;
    gg        = 1'b0;
    pn        = '0;
    gn        = '0;
    for (int j = 0; j < int'(GRP); j++) begin
      pn = s1_p[4*j +: 4];
      gn = s1_g[4*j +: 4];
      gp = &pn;
      gg = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1]) | (pn[3] & pn[2] & pn[1] & gn[0]);
      nc = gc;
      for (int i = 0; i < 4; i++) begin
        nib_cin_c[4*j + i] = nc;
        nc = gn[i] | (pn[i] & nc);
      end
      gc = gg | (gp & gc);
    end
    cout_c = gc;
  end

  // Nibble sums from the resolved carries, plus signed overflow.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(NIB); k++) begin
      sum_c[4*k +: 4] = 4'(s1_a[4*k +: 4] + s1_b[4*k +: 4] + 4'(nib_cin_c[k]));
    end
    ovf_c = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) & (sum_c[WIDTH-1] != s1_a[WIDTH-1]);
  end

  // Pipeline registers; each stage loads only when it may advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_p       <= '0;
      s1_g       <= '0;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_a   <= i_op_a;
          s1_b   <= b_eff_c;
          s1_cin <= i_sub;
          s1_p   <= p_c;
          s1_g   <= g_c;
        end
      end
      if (s2_adv) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_result   <= sum_c;
          o_carry    <= cout_c;
          o_overflow <= ovf_c;
          o_zero     <= (sum_c == '0);
          o_negative <= sum_c[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed/table-driven bench for cla_adder_pipe (WIDTH = 32).
module tb_cla_adder_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic        i_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic        o_carry;
  logic        o_overflow;
  logic        o_zero;
  logic        o_negative;

  int checks = 0;
  int errors = 0;

  cla_adder_pipe #(.WIDTH(32)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_zero     (o_zero),
    .o_negative (o_negative)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain 33-bit add of the conditioned operands.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    vec_t        r;
    logic [31:0] bp;
    logic [32:0] full;
    bp    = b ^ {32{sub}};
    full  = {1'b0, a} + {1'b0, bp} + 33'(sub);
    r.a   = a;
    r.b   = b;
    r.sub = sub;
    r.res = full[31:0];
    r.c   = full[32];
    r.v   = (a[31] == bp[31]) && (full[31] != a[31]);
    r.z   = (full[31:0] == 32'h0);
    r.n   = full[31];
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    i_valid = valid;
    i_op_a  = v.a;
    i_op_b  = v.b;
    i_sub   = v.sub;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, ".valid"},  32'(o_valid),    32'h1);
    chk({tag, ".result"}, o_result,        v.res);
    chk({tag, ".carry"},  32'(o_carry),    32'(v.c));
    chk({tag, ".ovf"},    32'(o_overflow), 32'(v.v));
    chk({tag, ".zero"},   32'(o_zero),     32'(v.z));
    chk({tag, ".neg"},    32'(o_negative), 32'(v.n));
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  vec_t tbl[12];
  vec_t stream_q[$];
  vec_t bp_ops[3];
  vec_t idle;
  vec_t snap;

  initial begin
    int idx;
    int rcv;

    // a, b, sub, result, carry, ovf, zero, neg
    tbl[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{32'h0F0F_0F0F, 32'h00F0_F0F1, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    idle = '{32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (tbl[i]) stream_q.push_back(tbl[i]);
    for (int i = 0; i < 8; i++)
      stream_q.push_back(model($urandom, $urandom, 1'($urandom_range(0, 1))));

    // Reset state
    i_rst_n = 1'b0;
    repeat (2) step();
    chk("rst.valid",  32'(o_valid), 32'h0);
    chk("rst.result", o_result,     32'h0);
    chk("rst.flags",  32'({o_carry, o_overflow, o_zero, o_negative}), 32'h0);
    i_rst_n = 1'b1;
    #1;
    chk("rst.ready",  32'(o_ready), 32'h1);
    step();

    // Back-to-back stream: result for op i appears two cycles after it is offered.
    for (int i = 0; i < stream_q.size() + 2; i++) begin
      if (i < stream_q.size()) drive(stream_q[i], 1'b1);
      else drive(idle, 1'b0);
      #1;
      chk($sformatf("stream%0d.ready", i), 32'(o_ready), 32'h1);
      if (i >= 2) check_out($sformatf("stream%0d", i - 2), stream_q[i - 2]);
      else chk($sformatf("stream_lat%0d.valid", i), 32'(o_valid), 32'h0);
      step();
    end
    #1;
    chk("stream_end.valid", 32'(o_valid), 32'h0);

    // Backpressure: three ops, i_ready low for the first six cycles.
    bp_ops[0] = tbl[2];
    bp_ops[1] = tbl[3];
    bp_ops[2] = tbl[8];
    idx = 0;
    rcv = 0;
    snap = idle;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 3) drive(bp_ops[idx], 1'b1);
      else drive(idle, 1'b0);
      i_ready = (cyc >= 6);
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        chk($sformatf("bp_stall%0d.ready", cyc), 32'(o_ready), 32'h0);
        check_out($sformatf("bp_hold%0d", cyc), bp_ops[0]);
      end
      if (o_valid && i_ready) begin
        if (rcv < 3) check_out($sformatf("bp_out%0d", rcv), bp_ops[rcv]);
        rcv++;
      end
      if (i_valid && o_ready) idx++;
      step();
    end
    chk("bp.accepted", 32'(idx), 32'd3);
    chk("bp.received", 32'(rcv), 32'd3);
    #1;
    chk("bp_end.valid", 32'(o_valid), 32'h0);

    // Reset with both stages full.
    i_ready = 1'b0;
    drive(tbl[2], 1'b1);
    step();
    drive(tbl[5], 1'b1);
    step();
    drive(idle, 1'b0);
    #1;
    check_out("rstfull.pre", tbl[2]);
    chk("rstfull.ready_pre", 32'(o_ready), 32'h0);
    i_rst_n = 1'b0;
    #1;
    chk("rstfull.valid",  32'(o_valid), 32'h0);
    chk("rstfull.result", o_result,     32'h0);
    chk("rstfull.flags",  32'({o_carry, o_overflow, o_zero, o_negative}), 32'h0);
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rstfull.idle%0d", i), 32'(o_valid), 32'h0);
      chk($sformatf("rstfull.ready%0d", i), 32'(o_ready), 32'h1);
    end

    // Fresh op after reset comes through normally.
    drive(tbl[7], 1'b1);
    step();
    drive(idle, 1'b0);
    #1;
    chk("post_rst.lat", 32'(o_valid), 32'h0);
    step();
    check_out("post_rst", tbl[7]);
    step();
    chk("post_rst.drained", 32'(o_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
